// File: rtl/dsp_data_mem_responder.sv
// Fixed-latency data-memory responder for the DSP core load/store port.
// One request in flight; byte-enabled writes; misaligned/out-of-range/conflicting requests answer with mem_err.
module dsp_data_mem_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [3:0]            mem_be,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_valid,
   output logic                  mem_err,
   output logic                  mem_busy
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned WORD_W = ADDR_WIDTH - 2;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BE_W   = DATA_WIDTH / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [1:0]            state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic [ADDR_WIDTH-1:0] req_addr, req_addr_nx;
   logic                  req_rd, req_rd_nx;
   logic                  req_wr, req_wr_nx;
   logic [BE_W-1:0]       req_be, req_be_nx;
   logic [DATA_WIDTH-1:0] req_data, req_data_nx;
   logic [DATA_WIDTH-1:0] data_nx;
   logic                  valid_nx, err_nx, busy_nx;
   logic                  req_err_c, wr_en_c;
   logic [IDX_W-1:0]      req_idx_c;

   assign req_idx_c = req_addr[2 +: IDX_W];
   assign req_err_c = (req_rd & req_wr) || (req_addr[1:0] != 2'b00)
                   || (req_addr[ADDR_WIDTH-1:2] >= WORD_W'(DEPTH));

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         req_addr     <= '0;
         req_rd       <= 1'b0;
         req_wr       <= 1'b0;
         req_be       <= '0;
         req_data     <= '0;
         mem_data_out <= '0;
         mem_valid    <= 1'b0;
         mem_err      <= 1'b0;
         mem_busy     <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         req_addr     <= req_addr_nx;
         req_rd       <= req_rd_nx;
         req_wr       <= req_wr_nx;
         req_be       <= req_be_nx;
         req_data     <= req_data_nx;
         mem_data_out <= data_nx;
         mem_valid    <= valid_nx;
         mem_err      <= err_nx;
         mem_busy     <= busy_nx;
      end
   end

   // Next-state, request capture and response computation
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      req_addr_nx = req_addr;
      req_rd_nx   = req_rd;
      req_wr_nx   = req_wr;
      req_be_nx   = req_be;
      req_data_nx = req_data;
      data_nx     = '0;
      valid_nx    = 1'b0;
      err_nx      = 1'b0;
      wr_en_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_read | mem_write) begin
               req_addr_nx = mem_addr;
               req_rd_nx   = mem_read;
               req_wr_nx   = mem_write;
               req_be_nx   = mem_be;
               req_data_nx = mem_data_in;
               cnt_nx      = CNT_W'(LATENCY - 1);
               state_nx    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_nx = S_RESP;
               valid_nx = 1'b1;
               err_nx   = req_err_c;
               if (!req_err_c && req_rd) data_nx = mem[req_idx_c];
               wr_en_c  = !req_err_c && req_wr;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   // Array keeps its contents through reset; a write pending at a reset edge is dropped
   always_ff @(posedge clk) begin
      if (wr_en_c && !rst) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (req_be[i]) mem[req_idx_c][8*i +: 8] <= req_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dsp_data_mem_responder.sv
// Directed bench for dsp_data_mem_responder: transaction-level reference model plus literal checks.
module tb_dsp_data_mem_responder;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [3:0]  mem_be = '0;
   logic [31:0] mem_data_in = '0;
   logic [31:0] mem_data_out;
   logic        mem_valid, mem_err, mem_busy;

   int tests = 0;
   int fails = 0;

   dsp_data_mem_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read),
      .mem_write(mem_write), .mem_be(mem_be), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_valid(mem_valid), .mem_err(mem_err),
      .mem_busy(mem_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding request, answered LAT edges after acceptance
   logic [31:0] mm [int];
   bit          m_pend = 0;
   int          m_resp_edge = 0;
   int          cyc = 0;
   bit          m_rd, m_wr;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_be;
   bit          e_valid = 0, e_err = 0, e_busy = 0, e_known = 1, was_busy;
   logic [31:0] e_data = '0, w;
   logic [29:0] m_idx;
   bit          model_on = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_pend = 0; e_valid = 0; e_err = 0; e_data = '0; e_busy = 0; e_known = 1;
         model_on = 1;
      end else if (model_on) begin
         was_busy = e_busy;
         e_valid = 0; e_err = 0; e_data = '0; e_known = 1;
         if (m_pend && cyc == m_resp_edge) begin
            m_pend  = 0;
            e_valid = 1;
            m_idx   = m_addr[31:2];
            e_err   = (m_rd && m_wr) || (m_addr[1:0] != 2'b00) || (m_idx >= 30'(DEPTH));
            if (!e_err && m_rd) begin
               if (mm.exists(int'(m_idx))) e_data = mm[int'(m_idx)];
               else e_known = 0;
            end else if (!e_err && m_wr) begin
               w = mm.exists(int'(m_idx)) ? mm[int'(m_idx)] : 32'h0;
               for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_data[8*b +: 8];
               if (m_be != 4'b0000) mm[int'(m_idx)] = w;
            end
         end else if (!was_busy && (mem_read || mem_write)) begin
            m_pend = 1; m_resp_edge = cyc + int'(LAT);
            m_rd = mem_read; m_wr = mem_write; m_addr = mem_addr;
            m_be = mem_be; m_data = mem_data_in;
         end
         e_busy = m_pend || e_valid;
      end
   end

   // Cycle-by-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (model_on) begin
         check("model_valid", 32'(mem_valid), 32'(e_valid));
         check("model_busy", 32'(mem_busy), 32'(e_busy));
         if (e_valid) begin
            check("model_err", 32'(mem_err), 32'(e_err));
            if (e_known) check("model_data", mem_data_out, e_data);
         end
      end
   end

   task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] data);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_addr = addr; mem_be = be; mem_data_in = data;
   endtask

   task automatic clear_req();
      mem_read = 0; mem_write = 0; mem_addr = '0; mem_be = '0; mem_data_in = '0;
   endtask

   // Waits for the single response strobe and checks latency, payload and pulse width
   task automatic wait_resp(input string name, input bit exp_err, input logic [31:0] exp_data);
      int n = 0;
      bit found = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(negedge clk);
         if (i == 1) clear_req();
         if (mem_valid) begin found = 1; n = i; end
      end
      if (!found) begin
         tests++; fails++;
         $display("FAIL %s_timeout: no mem_valid within 20 cycles", name);
      end else begin
         check({name, "_lat"}, 32'(n), 32'(LAT + 1));
         check({name, "_err"}, 32'(mem_err), 32'(exp_err));
         check({name, "_data"}, mem_data_out, exp_data);
         @(negedge clk);
         check({name, "_vfall"}, 32'(mem_valid), 32'd0);
      end
   endtask

   int          vcnt;
   logic [31:0] vdata;

   initial begin
      rst = 1;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(mem_valid), 32'd0);
      check("rst_busy", 32'(mem_busy), 32'd0);
      check("rst_err", 32'(mem_err), 32'd0);
      check("rst_data", mem_data_out, 32'd0);
      rst = 0;

      req(0, 1, 32'h10, 4'b1111, 32'hDEADBEEF); wait_resp("wr10", 0, 32'h0);
      req(1, 0, 32'h10, 4'b0000, 32'h0);        wait_resp("rd10", 0, 32'hDEADBEEF);
      req(0, 1, 32'h10, 4'b0101, 32'h11223344); wait_resp("wrbe", 0, 32'h0);
      req(1, 0, 32'h10, 4'b0000, 32'h0);        wait_resp("rdbe", 0, 32'hDE22BE44);
      req(0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF); wait_resp("wrbe0", 0, 32'h0);
      req(1, 0, 32'h10, 4'b0000, 32'h0);        wait_resp("rdbe0", 0, 32'hDE22BE44);

      req(1, 0, 32'h11, 4'b0000, 32'h0);        wait_resp("mis", 1, 32'h0);
      req(1, 0, DEPTH * 4, 4'b0000, 32'h0);     wait_resp("oor", 1, 32'h0);
      req(1, 0, 32'h8000_0010, 4'b0000, 32'h0); wait_resp("oorhi", 1, 32'h0);
      req(1, 1, 32'h10, 4'b1111, 32'h55555555); wait_resp("rdwr", 1, 32'h0);
      req(1, 0, 32'h10, 4'b0000, 32'h0);        wait_resp("rdwr_keep", 0, 32'hDE22BE44);
      req(0, 1, (DEPTH - 1) * 4, 4'b1111, 32'hA5A5_0FF0); wait_resp("wrtop", 0, 32'h0);
      req(1, 0, (DEPTH - 1) * 4, 4'b0000, 32'h0);         wait_resp("rdtop", 0, 32'hA5A5_0FF0);
      req(0, 1, 32'h20, 4'b1111, 32'h01234567); wait_resp("wr20", 0, 32'h0);

      // Second request one cycle later lands while busy and must vanish
      req(1, 0, 32'h10, 4'b0000, 32'h0);
      req(1, 0, 32'h20, 4'b0000, 32'h0);
      @(negedge clk); clear_req();
      vcnt = 0; vdata = '0;
      for (int i = 0; i < 8; i++) begin
         if (mem_valid) begin vcnt++; vdata = mem_data_out; end
         @(negedge clk);
      end
      check("busy_count", 32'(vcnt), 32'd1);
      check("busy_data", vdata, 32'hDE22BE44);

      // Reset during WAIT drops the write and its response
      req(0, 1, 32'h20, 4'b1111, 32'hCAFEF00D);
      @(negedge clk); clear_req(); rst = 1;
      @(negedge clk); rst = 0;
      check("rstmid_busy", 32'(mem_busy), 32'd0);
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_valid) vcnt++;
         @(negedge clk);
      end
      check("rstmid_novalid", 32'(vcnt), 32'd0);
      req(1, 0, 32'h20, 4'b0000, 32'h0);        wait_resp("rstmid_rd", 0, 32'h01234567);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
